// File: rtl/envelope_vca_if.sv
`default_nettype none
// ============================================================================
//  Module   : envelope_vca_if
//  Purpose  : Sample/envelope bundle between the ADSR envelope generator
//             side (master) and the envelope_vca amplifier (slave).
//  Signals  : sample_in        signed input sample
//             sample_in_valid  1-cycle strobe, one per audio sample
//             envelope         unsigned envelope amplitude
//             sample_out       signed scaled sample, held until next result
//             sample_out_valid 1-cycle result strobe
//             busy             multiply in flight
//             overrun          sticky, strobe arrived while busy
//  Revision : 1.0  initial release
// ============================================================================
interface envelope_vca_if #(
    parameter int BITSIZE  = 16,
    parameter int ENV_BITS = 16
);
    logic [BITSIZE-1:0]  sample_in;
    logic                sample_in_valid;
    logic [ENV_BITS-1:0] envelope;
    logic [BITSIZE-1:0]  sample_out;
    logic                sample_out_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_in, sample_in_valid, envelope,
        input  sample_out, sample_out_valid, busy, overrun
    );

    modport slave (
        input  sample_in, sample_in_valid, envelope,
        output sample_out, sample_out_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/envelope_vca.sv
`default_nettype none
// ============================================================================
//  Module   : envelope_vca
//  Purpose  : Voltage-controlled amplifier after the ADSR envelope generator.
//             Multiplies a signed sample by an unsigned envelope with a
//             serial LSB-first shift-add multiplier, scales so that
//             2**(ENV_BITS-2) is unity gain, saturates and emits one result
//             per accepted sample.
//  Ports    : clk  system clock
//             rst  synchronous active-high reset
//             bus  envelope_vca_if.slave (sample/envelope in, result out,
//                  busy, sticky overrun)
//  Options  : VCA_SLEW_EN - when defined, the effective envelope moves at
//             most SLEW_STEP per accepted sample toward the input envelope.
//  Timing   : accept on edge N, sample_out_valid high after edge N+ENV_BITS+2
//  Revision : 1.0  initial release
// ============================================================================
module envelope_vca #(
    parameter int BITSIZE   = 16,
    parameter int ENV_BITS  = 16,
    parameter int SLEW_STEP = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    envelope_vca_if.slave      bus
);
    localparam int ACC_W = BITSIZE + ENV_BITS;
    localparam int CNT_W = (ENV_BITS > 1) ? $clog2(ENV_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENV_BITS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

    // SAT registers the shifted/saturated value so the wide compare does not
    // sit in the same path as the output register.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SAT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BITSIZE-1:0]  sample_q;
    logic [ENV_BITS-1:0] env_eff_q;
    logic [ENV_BITS-1:0] env_eff_d;
    logic [ACC_W-1:0]    acc_q;
    logic [BITSIZE-1:0]  res_q;
    logic [BITSIZE-1:0]  sample_out_q;
    logic                valid_q;
    logic                busy_q;
    logic                overrun_q;

    logic [ACC_W-1:0]        w_pp;
    logic signed [ACC_W-1:0] w_shifted;
    logic [BITSIZE-1:0]      w_sat;

`ifdef VCA_SLEW_EN
    localparam logic [ENV_BITS:0] STEP_X = (ENV_BITS+1)'(SLEW_STEP);
    logic [ENV_BITS:0] w_env_x;
    logic [ENV_BITS:0] w_eff_x;

    // Compared one bit wider so eff+STEP / env+STEP never wrap.
    always_comb begin
        w_env_x = {1'b0, bus.envelope};
        w_eff_x = {1'b0, env_eff_q};
        if (w_env_x > w_eff_x + STEP_X)
            env_eff_d = env_eff_q + STEP_X[ENV_BITS-1:0];
        else if (w_env_x + STEP_X < w_eff_x)
            env_eff_d = env_eff_q - STEP_X[ENV_BITS-1:0];
        else
            env_eff_d = bus.envelope;
    end
`else
    logic w_unused_slew;
    assign w_unused_slew = ^SLEW_STEP;
    assign env_eff_d     = bus.envelope;
`endif

    // Sign-extended sample shifted to the weight of the current envelope bit.
    assign w_pp = env_eff_q[cnt_q]
                ? ({{ENV_BITS{sample_q[BITSIZE-1]}}, sample_q} << cnt_q)
                : '0;

    // Arithmetic shift floors toward -inf, matching the gain scaling.
    assign w_shifted = $signed(acc_q) >>> (ENV_BITS - 2);

    always_comb begin
        if (w_shifted > SAT_MAX)
            w_sat = {1'b0, {(BITSIZE-1){1'b1}}};
        else if (w_shifted < SAT_MIN)
            w_sat = {1'b1, {(BITSIZE-1){1'b0}}};
        else
            w_sat = w_shifted[BITSIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sample_q     <= '0;
            env_eff_q    <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            sample_out_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q != S_IDLE && bus.sample_in_valid)
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (bus.sample_in_valid) begin
                        sample_q  <= bus.sample_in;
                        env_eff_q <= env_eff_d;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_q + w_pp;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= S_SAT;
                end
                S_SAT: begin
                    res_q   <= w_sat;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    sample_out_q <= res_q;
                    valid_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.sample_out       = sample_out_q;
    assign bus.sample_out_valid = valid_q;
    assign bus.busy             = busy_q;
    assign bus.overrun          = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_envelope_vca.sv
`default_nettype none
// ============================================================================
//  Module   : tb_envelope_vca
//  Purpose  : Self-checking bench for envelope_vca: directed gain, latency,
//             saturation, overrun and reset cases plus randomized samples
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_envelope_vca;
    localparam int BITSIZE   = 16;
    localparam int ENV_BITS  = 16;
    localparam int SLEW_STEP = 64;
    localparam int LATENCY   = ENV_BITS + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_eff       = 0;

    always #5 clk = ~clk;

    envelope_vca_if #(.BITSIZE(BITSIZE), .ENV_BITS(ENV_BITS)) bus ();

    envelope_vca #(
        .BITSIZE  (BITSIZE),
        .ENV_BITS (ENV_BITS),
        .SLEW_STEP(SLEW_STEP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: product scaled by 2**(ENV_BITS-2) with floor, then clamped.
    function automatic logic [15:0] model(input logic [15:0] s, input int e);
        longint p;
        longint r;
        p = longint'($signed(s)) * longint'(e);
        r = p >>> (ENV_BITS - 2);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    // Effective envelope seen by an accepted sample.
    function automatic void model_accept(input int e);
`ifdef VCA_SLEW_EN
        if (e > m_eff + SLEW_STEP)      m_eff = m_eff + SLEW_STEP;
        else if (e + SLEW_STEP < m_eff) m_eff = m_eff - SLEW_STEP;
        else                            m_eff = e;
`else
        m_eff = e;
`endif
    endfunction

    task automatic run_sample(input logic [15:0] s, input logic [15:0] e,
                              input int extra_at, input string tag,
                              output logic [15:0] obs);
        int lat;
        int busy_cnt;
        logic [15:0] exp;
        model_accept(int'(e));
        exp = model(s, m_eff);
        @(negedge clk);
        bus.sample_in       = s;
        bus.envelope        = e;
        bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.sample_out_valid) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            bus.sample_in_valid = (k == extra_at);
            @(negedge clk);
        end
        bus.sample_in_valid = 1'b0;
        obs = bus.sample_out;
        check({tag, " latency"}, 64'(lat), 64'(LATENCY));
        check({tag, " value"}, 64'(bus.sample_out), 64'(exp));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(LATENCY));
        check({tag, " busy clear"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check({tag, " valid width"}, 64'(bus.sample_out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        m_eff = 0;
    endtask

    initial begin
        logic [15:0] obs;
        int valid_seen;
        bus.sample_in       = '0;
        bus.envelope        = '0;
        bus.sample_in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset sample_out", 64'(bus.sample_out), 64'd0);
        check("reset valid", 64'(bus.sample_out_valid), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset overrun", 64'(bus.overrun), 64'd0);
        rst = 1'b0;

        // Unity gain, scaling, zero gain, saturation both ways
        run_sample(16'h1234, 16'h4000, -1, "unity", obs);
        run_sample(16'hC000, 16'h2000, -1, "half neg", obs);
        run_sample(16'h5555, 16'h0000, -1, "zero env", obs);
        run_sample(16'h7000, 16'hFFFF, -1, "sat pos", obs);
        run_sample(16'h8000, 16'hFFFF, -1, "sat neg", obs);
        check("no overrun yet", 64'(bus.overrun), 64'd0);

        // Second strobe 5 cycles after the first is dropped
        run_sample(16'h2222, 16'h4000, 4, "overrun first", obs);
        check("overrun set", 64'(bus.overrun), 64'd1);
        run_sample(16'h0100, 16'h4000, -1, "overrun sticky run", obs);
        check("overrun sticky", 64'(bus.overrun), 64'd1);
        do_reset();
        check("overrun cleared", 64'(bus.overrun), 64'd0);

        // Reset 8 cycles into the multiply
        run_sample(16'h0ABC, 16'h4000, -1, "pre abort", obs);
        model_accept(16'h4000);
        @(negedge clk);
        bus.sample_in       = 16'h1111;
        bus.envelope        = 16'h4000;
        bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort sample_out", 64'(bus.sample_out), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort valid", 64'(bus.sample_out_valid), 64'd0);
        rst   = 1'b0;
        m_eff = 0;
        valid_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.sample_out_valid) valid_seen++;
        end
        check("abort no valid", 64'(valid_seen), 64'd0);
        run_sample(16'h0333, 16'h4000, -1, "post abort", obs);

        // Envelope step 0 -> unity
        do_reset();
        run_sample(16'h4000, 16'h0000, -1, "step low", obs);
        run_sample(16'h4000, 16'h4000, -1, "step 1", obs);
`ifdef VCA_SLEW_EN
        check("step first output", 64'(obs), 64'h0040);
`else
        check("step first output", 64'(obs), 64'h4000);
`endif
        run_sample(16'h4000, 16'h4000, -1, "step 2", obs);

        // Randomized samples and envelopes
        for (int i = 0; i < 24; i++) begin
            logic [15:0] rs;
            logic [15:0] re;
            rs = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       re = 16'($urandom_range(0, 16'h3FFF));
                1:       re = 16'h4000;
                2:       re = 16'($urandom);
                default: re = 16'($urandom_range(16'hF000, 16'hFFFF));
            endcase
            run_sample(rs, re, -1, "random", obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
